// File: rtl/regm_wctrl_if.sv
// Write-port bundle between the two writeback requesters, the controller and the register file.
// The master side issues requests; the slave side is the controller.
interface regm_wctrl_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        init_done;
  logic        write;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  init_done, write, waddr, wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output init_done, write, waddr, wdata
  );
endinterface

// File: rtl/regm_wctrl.sv
// Register-file write-port controller: zero-init sweep of x1..x31 after reset, then
// round-robin arbitration of the single write port between two writeback requesters.
module regm_wctrl #(
  parameter bit          INIT_ENABLE = 1'b1,
  parameter logic [31:0] INIT_VALUE  = 32'h0
) (
  input logic         clk,
  input logic         rst,
  regm_wctrl_if.slave bus
);

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;
  localparam logic [0:0] StReset = INIT_ENABLE ? StInit : StRun;

  logic [0:0]  state_q;
  logic [4:0]  cnt_q;
  logic        rr_last_q;
  logic        write_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic        init_done_q;

  logic        gnt0;
  logic        gnt1;
  logic        contested;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  // rr_last_q == 1 means requester 1 won the last contest, so requester 0 is preferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == StRun) begin
      if (bus.req0_valid && (!bus.req1_valid || rr_last_q)) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign contested = bus.req0_valid && bus.req1_valid;
  assign win_addr  = gnt0 ? bus.req0_addr : bus.req1_addr;
  assign win_data  = gnt0 ? bus.req0_data : bus.req1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StReset;
      cnt_q       <= 5'd1;
      rr_last_q   <= 1'b1;
      write_q     <= 1'b0;
      waddr_q     <= 5'd0;
      wdata_q     <= 32'd0;
      init_done_q <= !INIT_ENABLE;
    end else begin
      case (state_q)
        StInit: begin
          write_q <= 1'b1;
          waddr_q <= cnt_q;
          wdata_q <= INIT_VALUE;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          // Writes to x0 are accepted but never issued; address/data then hold.
          write_q <= (gnt0 || gnt1) && (win_addr != 5'd0);
          if ((gnt0 || gnt1) && (win_addr != 5'd0)) begin
            waddr_q <= win_addr;
            wdata_q <= win_data;
          end
          if (contested) begin
            rr_last_q <= gnt1;
          end
        end
      endcase
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.init_done  = init_done_q;
  assign bus.write      = write_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;

endmodule

// File: tb/tb_regm_wctrl.sv
// Directed bench for regm_wctrl: init sweep, single/contended requests, x0 writes,
// reset mid-sweep, and the INIT_ENABLE=0 variant.
module tb_regm_wctrl;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  regm_wctrl_if bus_a ();
  regm_wctrl_if bus_b ();

  regm_wctrl #(
    .INIT_ENABLE (1'b1),
    .INIT_VALUE  (32'hDEADBEEF)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  regm_wctrl #(
    .INIT_ENABLE (1'b0),
    .INIT_VALUE  (32'h0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps through n sweep writes of dut_a; valids are dropped before the RUN edge.
  task automatic sweep(input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      check("sweep_write", {31'd0, bus_a.write}, 32'd1);
      check("sweep_waddr", {27'd0, bus_a.waddr}, i);
      check("sweep_wdata", bus_a.wdata, 32'hDEADBEEF);
      check("sweep_done", {31'd0, bus_a.init_done}, (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) begin
        check("sweep_rdy0", {31'd0, bus_a.req0_ready}, 32'd0);
        check("sweep_rdy1", {31'd0, bus_a.req1_ready}, 32'd0);
      end
      if (i == 30) begin
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
      end
    end
  endtask

  initial begin
    timeout_guard: begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.req0_valid = 1'b1;
    bus_a.req0_addr  = 5'd2;
    bus_a.req0_data  = 32'h1;
    bus_a.req1_valid = 1'b1;
    bus_a.req1_addr  = 5'd4;
    bus_a.req1_data  = 32'h2;
    bus_b.req0_valid = 1'b0;
    bus_b.req0_addr  = 5'd0;
    bus_b.req0_data  = 32'h0;
    bus_b.req1_valid = 1'b0;
    bus_b.req1_addr  = 5'd0;
    bus_b.req1_data  = 32'h0;
    #2;

    // Reset state with both valids high.
    check("rst_write", {31'd0, bus_a.write}, 32'd0);
    check("rst_waddr", {27'd0, bus_a.waddr}, 32'd0);
    check("rst_wdata", bus_a.wdata, 32'd0);
    check("rst_done", {31'd0, bus_a.init_done}, 32'd0);
    check("rst_rdy0", {31'd0, bus_a.req0_ready}, 32'd0);
    check("rst_rdy1", {31'd0, bus_a.req1_ready}, 32'd0);

    @(negedge clk);
    rst_a = 1'b0;
    sweep(31);
    step();
    check("post_sweep_write", {31'd0, bus_a.write}, 32'd0);
    check("post_sweep_done", {31'd0, bus_a.init_done}, 32'd1);

    // Single requester.
    bus_a.req0_valid = 1'b1;
    bus_a.req0_addr  = 5'd5;
    bus_a.req0_data  = 32'h12345678;
    #1;
    check("single_rdy0", {31'd0, bus_a.req0_ready}, 32'd1);
    check("single_rdy1", {31'd0, bus_a.req1_ready}, 32'd0);
    step();
    bus_a.req0_valid = 1'b0;
    check("single_write", {31'd0, bus_a.write}, 32'd1);
    check("single_waddr", {27'd0, bus_a.waddr}, 32'd5);
    check("single_wdata", bus_a.wdata, 32'h12345678);
    step();
    check("single_idle", {31'd0, bus_a.write}, 32'd0);

    // Sustained contention: grants 0,1,0,1.
    bus_a.req0_valid = 1'b1;
    bus_a.req0_addr  = 5'd3;
    bus_a.req0_data  = 32'hA0A0A0A0;
    bus_a.req1_valid = 1'b1;
    bus_a.req1_addr  = 5'd7;
    bus_a.req1_data  = 32'hB1B1B1B1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("cont_rdy0", {31'd0, bus_a.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_rdy1", {31'd0, bus_a.req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      step();
      if (k == 3) begin
        bus_a.req0_valid = 1'b0;
        bus_a.req1_valid = 1'b0;
      end
      check("cont_write", {31'd0, bus_a.write}, 32'd1);
      check("cont_waddr", {27'd0, bus_a.waddr}, (k % 2 == 0) ? 32'd3 : 32'd7);
      check("cont_wdata", bus_a.wdata, (k % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
    end

    // Write to x0 is accepted but never issued.
    bus_a.req1_valid = 1'b1;
    bus_a.req1_addr  = 5'd0;
    bus_a.req1_data  = 32'hFFFFFFFF;
    #1;
    check("x0_rdy1", {31'd0, bus_a.req1_ready}, 32'd1);
    step();
    bus_a.req1_valid = 1'b0;
    check("x0_write", {31'd0, bus_a.write}, 32'd0);

    // Reset mid-sweep, then a full restart.
    rst_a = 1'b1;
    #1;
    check("rst2_done", {31'd0, bus_a.init_done}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    sweep(10);
    rst_a = 1'b1;
    #1;
    check("midrst_write", {31'd0, bus_a.write}, 32'd0);
    check("midrst_waddr", {27'd0, bus_a.waddr}, 32'd0);
    check("midrst_wdata", bus_a.wdata, 32'd0);
    check("midrst_done", {31'd0, bus_a.init_done}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    bus_a.req0_valid = 1'b1;
    bus_a.req1_valid = 1'b1;
    sweep(31);
    step();
    check("resweep_idle", {31'd0, bus_a.write}, 32'd0);

    // INIT_ENABLE=0: ready immediately, no sweep.
    check("noinit_rst_done", {31'd0, bus_b.init_done}, 32'd1);
    check("noinit_rst_write", {31'd0, bus_b.write}, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    bus_b.req0_valid = 1'b1;
    bus_b.req0_addr  = 5'd9;
    bus_b.req0_data  = 32'h00000055;
    #1;
    check("noinit_rdy0", {31'd0, bus_b.req0_ready}, 32'd1);
    check("noinit_done", {31'd0, bus_b.init_done}, 32'd1);
    step();
    bus_b.req0_valid = 1'b0;
    check("noinit_write", {31'd0, bus_b.write}, 32'd1);
    check("noinit_waddr", {27'd0, bus_b.waddr}, 32'd9);
    check("noinit_wdata", bus_b.wdata, 32'h00000055);
    step();
    check("noinit_idle", {31'd0, bus_b.write}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regm_wctrl.md
Name: regm_wctrl

Overview:
Write-port controller for the 32x32 register file: single write port (write/waddr/wdata), x0 hardwired to zero.
After reset it sequences a zero-initialisation of registers x1..x31. It then arbitrates the single write port between two writeback requesters: req0 (execute-stage result) and req1 (load/store result).
Its outputs drive the register file's write_i/waddr_i/wdata_i inputs directly.

Parameters:
INIT_ENABLE, 1, 1: run the init sweep after reset; 0: start directly in RUN.
INIT_VALUE, 32'h0, value written to x1..x31 during the init sweep.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
req0_valid_i  input  1  requester 0 has a write pending
req0_ready_o  output  1  requester 0 write accepted this cycle
req0_addr_i  input  5  requester 0 destination register
req0_data_i  input  32  requester 0 write data
req1_valid_i  input  1  requester 1 has a write pending
req1_ready_o  output  1  requester 1 write accepted this cycle
req1_addr_i  input  5  requester 1 destination register
req1_data_i  input  32  requester 1 write data
init_done_o  output  1  init sweep finished; port available to requesters
write_o  output  1  register-file write enable
waddr_o  output  5  register-file write address
wdata_o  output  32  register-file write data

Behaviour:
- Reset (async, rst_i=1):
  - state = INIT if INIT_ENABLE, else RUN; cnt = 1; rr_last = 1 (req0 preferred next).
  - write_o = 0, waddr_o = 0, wdata_o = 0.
  - init_done_o = 0 if INIT_ENABLE, else 1.
- Reset asserted mid-sweep or mid-transfer: immediate return to reset values. The sweep restarts from x1 after deassertion. A transfer accepted in the edge before reset and not yet presented is dropped.
- State INIT:
  - req0_ready_o = req1_ready_o = 0.
  - Each edge: write_o <= 1, waddr_o <= cnt, wdata_o <= INIT_VALUE, cnt <= cnt+1.
  - At the edge where cnt == 31: state <= RUN, init_done_o <= 1.
  - The sweep therefore writes exactly 31 registers (x1..x31) over 31 consecutive cycles. x0 is never written.
- State RUN:
  - Terminal state; left only by reset. init_done_o stays 1.
  - Grant logic is combinational from the valids and rr_last:
    - Only reqN valid: grant N.
    - Both valid: grant 0 if rr_last == 1, else grant 1.
  - reqN_ready_o = grant N; at most one ready per cycle. A transfer occurs when valid & ready.
  - rr_last updates only on a contested grant (both valid), to the granted index. Uncontested grants leave it unchanged.
  - Latency 1: a transfer at edge N drives write_o=1 with waddr_o/wdata_o from the winner during cycle N+1.
  - No transfer: write_o <= 0; waddr_o/wdata_o hold their previous values.
  - Transfer with addr == 0: accepted (ready=1) but write_o <= 0. A write to x0 is never issued.
- Requesters hold addr/data stable while valid and not ready. Behaviour under a protocol violation is undefined.
- Throughput: one write per cycle. Under sustained contention, req0 and req1 strictly alternate.

Test Plan:
- INIT_ENABLE=1, INIT_VALUE=32'hDEADBEEF, release reset:
  - write_o=1 for exactly 31 cycles, waddr_o=1..31 in order, wdata_o=DEADBEEF.
  - init_done_o rises at the same edge waddr_o=31 appears.
  - No ready asserted before init_done_o=1, even with both valids held high.
- Single requester, RUN: req0 valid, addr=5, data=32'h12345678 for one cycle.
  - req0_ready_o=1 that cycle.
  - Next cycle write_o=1, waddr_o=5, wdata_o=12345678; following cycle write_o=0.
- Contention: both valid continuously for 4 cycles (req0 addr=3, req1 addr=7, distinct data).
  - Grants are 0,1,0,1; waddr_o is 3,7,3,7 one cycle later.
  - Exactly one ready per cycle.
- x0 write: req1 valid, addr=0, data=32'hFFFFFFFF.
  - req1_ready_o=1; write_o stays 0 the next cycle.
- Reset mid-sweep: assert rst_i asynchronously after the write with waddr_o=10.
  - Outputs go to 0 immediately; after release the sweep restarts at waddr_o=1 and runs 31 writes.
- INIT_ENABLE=0: init_done_o=1 during and after reset.
  - A req0 request on the first cycle after release is accepted immediately; no sweep writes occur.
